exp8_input_conditioner: RTL

//  Upstream stage of the Exp8 w/x state machine. Conditions two raw pushbuttons
//  (BtnW, BtnX) into clean single-cycle w/x codes sampled by the FSM on Clk:

---
 rtl/exp8_input_conditioner_if.sv | 11 +
 rtl/exp8_input_conditioner.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/exp8_input_conditioner_if.sv
// Pushbutton/code bundle between the raw buttons and the Exp8 w/x state machine.
// Buttons are driven by the master; registered codes come back from the conditioner.
interface exp8_input_conditioner_if;
  logic BtnW;
  logic BtnX;
  logic w;
  logic x;

  modport master (output BtnW, output BtnX, input w, input x);
  modport slave  (input BtnW, input BtnX, output w, output x);
endinterface

// File: rtl/exp8_input_conditioner.sv
// Turns two raw pushbuttons into single-cycle w/x codes for the Exp8 FSM:
// 2-FF sync, counter debounce, rising-edge detect, then pairing of near-simultaneous presses.
//
// state   | meaning
// S_IDLE  | no press pending
// S_GOT_W | W pressed, waiting up to PAIR_WINDOW cycles for X
// S_GOT_X | X pressed, waiting up to PAIR_WINDOW cycles for W
module exp8_input_conditioner #(
  parameter int DEBOUNCE_MAX = 50000,
  parameter int CNT_W        = 16,
  parameter int PAIR_WINDOW  = 1000,
  parameter int WIN_W        = 10
) (
  input  logic                     Clk,
  input  logic                     Reset,
  exp8_input_conditioner_if.slave  bus
);

  localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DEBOUNCE_MAX - 1);
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(PAIR_WINDOW - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GOT_W = 2'd1,
    S_GOT_X = 2'd2
  } state_t;

  // Channel index 0 is W, 1 is X.
  logic [1:0]       w_raw;
  logic [1:0]       r_sync1;
  logic [1:0]       r_sync2;
  logic [1:0]       r_stable;
  logic [1:0]       r_stable_d;
  logic [CNT_W-1:0] r_dcnt [2];
  logic [1:0]       w_ev;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIN_W-1:0] r_wcnt;
  logic [WIN_W-1:0] w_wcnt_nxt;
  logic             r_w;
  logic             r_x;
  logic             w_w_nxt;
  logic             w_x_nxt;

  assign w_raw = {bus.BtnX, bus.BtnW};

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_sync1    <= '0;
      r_sync2    <= '0;
      r_stable   <= '0;
      r_stable_d <= '0;
      for (int i = 0; i < 2; i++) r_dcnt[i] <= '0;
    end else begin
      r_sync1    <= w_raw;
      r_sync2    <= r_sync1;
      r_stable_d <= r_stable;
      for (int i = 0; i < 2; i++) begin
        if (r_sync2[i] == r_stable[i]) begin
          r_dcnt[i] <= '0;
        end else if (r_dcnt[i] == DB_LAST) begin
          r_stable[i] <= r_sync2[i];
          r_dcnt[i]   <= '0;
        end else begin
          r_dcnt[i] <= r_dcnt[i] + CNT_W'(1);
        end
      end
    end
  end

  // Press events only; releases never produce a code.
  assign w_ev = r_stable & ~r_stable_d;

  always_comb begin
    w_state_nxt = r_state;
    w_wcnt_nxt  = r_wcnt;
    w_w_nxt     = 1'b0;
    w_x_nxt     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_ev[0] && w_ev[1]) begin
          w_w_nxt = 1'b1;
          w_x_nxt = 1'b1;
        end else if (w_ev[0]) begin
          w_state_nxt = S_GOT_W;
          w_wcnt_nxt  = '0;
        end else if (w_ev[1]) begin
          w_state_nxt = S_GOT_X;
          w_wcnt_nxt  = '0;
        end
      end
      S_GOT_W: begin
        if (w_ev[1]) begin
          w_w_nxt     = 1'b1;
          w_x_nxt     = 1'b1;
          w_state_nxt = S_IDLE;
        end else if (r_wcnt == WIN_LAST) begin
          w_w_nxt     = 1'b1;
          w_state_nxt = S_IDLE;
        end else begin
          w_wcnt_nxt = r_wcnt + WIN_W'(1);
        end
      end
      S_GOT_X: begin
        if (w_ev[0]) begin
          w_w_nxt     = 1'b1;
          w_x_nxt     = 1'b1;
          w_state_nxt = S_IDLE;
        end else if (r_wcnt == WIN_LAST) begin
          w_x_nxt     = 1'b1;
          w_state_nxt = S_IDLE;
        end else begin
          w_wcnt_nxt = r_wcnt + WIN_W'(1);
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state <= S_IDLE;
      r_wcnt  <= '0;
      r_w     <= 1'b0;
      r_x     <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_wcnt  <= w_wcnt_nxt;
      r_w     <= w_w_nxt;
      r_x     <= w_x_nxt;
    end
  end

  assign bus.w = r_w;
  assign bus.x = r_x;

endmodule
